// File: rtl/convolution_pkg.sv
// Shared widths, saturation limits and sizing helpers for the convolution line.
package convolution_pkg;

    localparam int unsigned I_PSUM_W = 16;
    localparam int unsigned O_DATA_W = 8;
    localparam int unsigned ACC_W    = 24;

    localparam int SAT_MAX = (1 << (O_DATA_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (O_DATA_W - 1));

    function automatic int sat_max(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int unsigned w);
        return -(1 << (w - 1));
    endfunction

    // Tap-counter width; never narrower than one bit.
    function automatic int unsigned tap_cnt_w(input int unsigned k);
        return (k > 2) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/convolution_psum_collector_if.sv
// Psum input handshake plus result output handshake of the collector.
interface convolution_psum_collector_if
    import convolution_pkg::*;
#(
    parameter int unsigned I_PSUM = I_PSUM_W,
    parameter int unsigned O_DATA = O_DATA_W
);
    logic                     i_valid;
    logic                     o_in_ready;
    logic signed [I_PSUM-1:0] i_psum;
    logic signed [I_PSUM-1:0] i_bias;
    logic                     i_flush;
    logic                     o_valid;
    logic                     i_out_ready;
    logic signed [O_DATA-1:0] o_data;
    logic                     o_sat;

    modport master (
        output i_valid, i_psum, i_bias, i_flush, i_out_ready,
        input  o_in_ready, o_valid, o_data, o_sat
    );

    modport slave (
        input  i_valid, i_psum, i_bias, i_flush, i_out_ready,
        output o_in_ready, o_valid, o_data, o_sat
    );
endinterface

// File: rtl/convolution_requant.sv
// Combinational requantizer: optional ReLU, floor arithmetic shift, signed saturation.
module convolution_requant
    import convolution_pkg::*;
#(
    parameter int unsigned ACC    = ACC_W,
    parameter int unsigned SHIFT  = 4,
    parameter int unsigned RELU   = 1,
    parameter int unsigned O_DATA = O_DATA_W
) (
    input  logic signed [ACC-1:0]    sum,
    output logic signed [O_DATA-1:0] data,
    output logic                     clipped
);
    localparam logic signed [ACC-1:0] HI = ACC'(sat_max(O_DATA));
    localparam logic signed [ACC-1:0] LO = ACC'(sat_min(O_DATA));

    logic signed [ACC-1:0] relu_v;
    logic signed [ACC-1:0] shifted;

    always_comb begin
        relu_v  = sum;
        if ((RELU != 0) && sum[ACC-1]) relu_v = '0;
        shifted = relu_v >>> SHIFT;
        data    = O_DATA'(shifted);
        clipped = 1'b0;
        if (shifted > HI) begin
            data    = O_DATA'(HI);
            clipped = 1'b1;
        end else if (shifted < LO) begin
            data    = O_DATA'(LO);
            clipped = 1'b1;
        end
    end
endmodule

// File: rtl/convolution_psum_collector.sv
// Accumulates K psums per pixel plus bias and emits one requantized activation through a held output register.
module convolution_psum_collector
    import convolution_pkg::*;
#(
    parameter int unsigned I_PSUM = I_PSUM_W,
    parameter int unsigned K      = 4,
    parameter int unsigned ACC    = ACC_W,
    parameter int unsigned SHIFT  = 4,
    parameter int unsigned RELU   = 1,
    parameter int unsigned O_DATA = O_DATA_W
) (
    input logic                          i_clk,
    input logic                          i_rst_n,
    convolution_psum_collector_if.slave  bus
);
    localparam int unsigned   CW   = tap_cnt_w(K);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    logic [CW-1:0]             cnt_q, cnt_d;
    logic signed [ACC-1:0]     acc_q, acc_d;
    logic                      valid_q, valid_d;
    logic signed [O_DATA-1:0]  data_q, data_d;
    logic                      sat_q, sat_d;

    logic                      is_last;
    logic                      in_ready;
    logic                      in_fire;
    logic                      out_fire;
    logic signed [ACC-1:0]     psum_x;
    logic signed [ACC-1:0]     bias_x;
    logic signed [ACC-1:0]     sum_final;
    logic signed [O_DATA-1:0]  rq_data;
    logic                      rq_clip;

    assign psum_x    = ACC'(bus.i_psum);
    assign bias_x    = ACC'(bus.i_bias);
    assign sum_final = acc_q + psum_x + bias_x;

    // Only the final tap waits, and only while the held result is not leaving.
    assign is_last  = (cnt_q == LAST);
    assign in_ready = !(is_last && valid_q && !bus.i_out_ready);
    assign in_fire  = bus.i_valid && in_ready;
    assign out_fire = valid_q && bus.i_out_ready;

    convolution_requant #(
        .ACC    (ACC),
        .SHIFT  (SHIFT),
        .RELU   (RELU),
        .O_DATA (O_DATA)
    ) u_requant (
        .sum     (sum_final),
        .data    (rq_data),
        .clipped (rq_clip)
    );

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        valid_d = valid_q;
        data_d  = data_q;
        sat_d   = sat_q;
        if (out_fire) valid_d = 1'b0;
        // Flush drops any same-cycle psum but leaves a held result alone.
        if (bus.i_flush) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (in_fire) begin
            if (is_last) begin
                valid_d = 1'b1;
                data_d  = rq_data;
                sat_d   = rq_clip;
                cnt_d   = '0;
                acc_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                acc_d = (cnt_q == '0) ? psum_x : acc_q + psum_x;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.o_in_ready = in_ready;
    assign bus.o_valid    = valid_q;
    assign bus.o_data     = data_q;
    assign bus.o_sat      = sat_q;
endmodule

// File: tb/tb_convolution_psum_collector.sv
// Bench for the psum collector: RELU=1 and RELU=0 instances share stimulus, checked against an integer model.
module tb_convolution_psum_collector;
    localparam int K = 4;

    logic clk;
    logic rst_n;
    logic valid;
    logic flush;
    logic ordy;
    logic signed [15:0] psum;
    logic signed [15:0] bias;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_cnt;
    int          m_acc;
    bit          m_valid;
    logic [7:0]  m_dr, m_dl;
    bit          m_sr, m_sl;

    convolution_psum_collector_if if_r ();
    convolution_psum_collector_if if_l ();

    assign if_r.i_valid = valid;     assign if_l.i_valid = valid;
    assign if_r.i_psum = psum;       assign if_l.i_psum = psum;
    assign if_r.i_bias = bias;       assign if_l.i_bias = bias;
    assign if_r.i_flush = flush;     assign if_l.i_flush = flush;
    assign if_r.i_out_ready = ordy;  assign if_l.i_out_ready = ordy;

    convolution_psum_collector #(.RELU(1)) u_relu (.i_clk(clk), .i_rst_n(rst_n), .bus(if_r));
    convolution_psum_collector #(.RELU(0)) u_lin  (.i_clk(clk), .i_rst_n(rst_n), .bus(if_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void requant(input int sum, input bit relu, output logic [7:0] d, output bit s);
        int v;
        v = sum;
        if (relu && v < 0) v = 0;
        v = v >>> 4;
        s = 1'b0;
        if (v > 127) begin v = 127; s = 1'b1; end
        else if (v < -128) begin v = -128; s = 1'b1; end
        d = 8'(v);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_acc = 0; m_valid = 1'b0;
        m_dr = '0; m_dl = '0; m_sr = 1'b0; m_sl = 1'b0;
    endtask

    // Drives one cycle from posedge+1 to the next posedge+1 and advances the model; no checking here.
    task automatic drive_cycle(input bit v, input int p, input int b, input bit f, input bit r,
                               output logic [1:0] rdy_obs, output bit rdy_exp);
        bit in_x;
        valid = v; psum = 16'(p); bias = 16'(b); flush = f; ordy = r;
        @(negedge clk);
        rdy_obs = {if_r.o_in_ready, if_l.o_in_ready};
        rdy_exp = !(m_cnt == K - 1 && m_valid && !r);
        in_x = v && rdy_exp;
        if (m_valid && r) m_valid = 1'b0;
        if (f) begin
            m_cnt = 0; m_acc = 0;
        end else if (in_x) begin
            if (m_cnt == K - 1) begin
                requant(m_acc + p + b, 1'b1, m_dr, m_sr);
                requant(m_acc + p + b, 1'b0, m_dl, m_sl);
                m_valid = 1'b1; m_cnt = 0; m_acc = 0;
            end else begin
                m_acc = m_acc + p; m_cnt = m_cnt + 1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        valid = 0; flush = 0; ordy = 0; psum = 0; bias = 0;
        rst_n = 0;
        #2;
        total++;
        if ({if_r.o_valid, if_r.o_data, if_r.o_sat, if_l.o_valid, if_l.o_data, if_l.o_sat} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: got r=%b/%0d/%b l=%b/%0d/%b want all zero",
                     if_r.o_valid, if_r.o_data, if_r.o_sat, if_l.o_valid, if_l.o_data, if_l.o_sat);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
        model_reset();
        #1;
        total++;
        if ({if_r.o_in_ready, if_l.o_in_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 11", {if_r.o_in_ready, if_l.o_in_ready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int p[4] = '{100, 200, -50, 10};
        logic [1:0] ro; bit re;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(i < 4, (i < 4) ? p[i] : 0, 0, 0, 1, ro, re);
            total++;
            if ({if_r.o_valid, if_l.o_valid} !== {m_valid, m_valid}) begin
                bad++; $display("FAIL basic_valid cyc%0d: got %b%b want %b", i, if_r.o_valid, if_l.o_valid, m_valid);
            end
            if (i == 3) begin
                total++;
                if (if_r.o_valid !== 1'b1 || if_r.o_data !== 8'sd16 || if_r.o_sat !== 1'b0 || if_l.o_data !== 8'sd16) begin
                    bad++; $display("FAIL basic_pixel: got r=%0d l=%0d sat=%b want 16 16 0", if_r.o_data, if_l.o_data, if_r.o_sat);
                end
            end
        end
    endtask

    task automatic test_relu();
        int p[4] = '{-100, -100, -100, 0};
        logic [1:0] ro; bit re;
        for (int i = 0; i < 4; i++) drive_cycle(1, p[i], 0, 0, 1, ro, re);
        total++;
        if (if_r.o_valid !== 1'b1 || if_r.o_data !== 8'sd0 || if_r.o_sat !== 1'b0) begin
            bad++; $display("FAIL relu_on: got v=%b d=%0d s=%b want 1 0 0", if_r.o_valid, if_r.o_data, if_r.o_sat);
        end
        total++;
        if (if_l.o_valid !== 1'b1 || if_l.o_data !== -8'sd19 || if_l.o_sat !== 1'b0) begin
            bad++; $display("FAIL relu_off: got v=%b d=%0d s=%b want 1 -19 0", if_l.o_valid, if_l.o_data, if_l.o_sat);
        end
        drive_cycle(0, 0, 0, 0, 1, ro, re);
    endtask

    task automatic test_saturation();
        logic [1:0] ro; bit re;
        for (int i = 0; i < 4; i++) drive_cycle(1, 5000, 100, 0, 1, ro, re);
        total++;
        if ({if_r.o_data, if_r.o_sat, if_l.o_data, if_l.o_sat} !== {8'sd127, 1'b1, 8'sd127, 1'b1}) begin
            bad++; $display("FAIL saturation: got r=%0d/%b l=%0d/%b want 127/1", if_r.o_data, if_r.o_sat, if_l.o_data, if_l.o_sat);
        end
        drive_cycle(0, 0, 0, 0, 1, ro, re);
    endtask

    task automatic test_backpressure();
        logic [1:0] ro; bit re;
        for (int i = 0; i < 4; i++) drive_cycle(1, 16, 0, 0, 0, ro, re);
        // second pixel: taps 0..2 go in, tap 3 stalls for three cycles
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1, 32, 0, 0, 0, ro, re);
            total++;
            if (ro !== {re, re} || re !== (i < 3)) begin
                bad++; $display("FAIL bp_in_ready cyc%0d: got %b want %b", i, ro, (i < 3));
            end
            total++;
            if ({if_r.o_valid, if_r.o_data, if_l.o_data} !== {1'b1, 8'sd4, 8'sd4}) begin
                bad++; $display("FAIL bp_hold cyc%0d: got v=%b d=%0d want 1 4", i, if_r.o_valid, if_r.o_data);
            end
        end
        drive_cycle(1, 32, 0, 0, 1, ro, re);
        total++;
        if (ro !== 2'b11 || {if_r.o_valid, if_r.o_data, if_l.o_valid, if_l.o_data} !== {1'b1, 8'sd8, 1'b1, 8'sd8}) begin
            bad++; $display("FAIL bp_release: got rdy=%b v=%b d=%0d want 11 1 8", ro, if_r.o_valid, if_r.o_data);
        end
        drive_cycle(0, 0, 0, 0, 1, ro, re);
        total++;
        if ({if_r.o_valid, if_l.o_valid} !== 2'b00) begin
            bad++; $display("FAIL bp_drain: got %b%b want 00", if_r.o_valid, if_l.o_valid);
        end
    endtask

    task automatic test_flush();
        logic [1:0] ro; bit re;
        drive_cycle(1, 100, 0, 0, 1, ro, re);
        drive_cycle(1, 100, 0, 0, 1, ro, re);
        drive_cycle(1, 100, 0, 1, 1, ro, re);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1, 16, 0, 0, 1, ro, re);
            total++;
            if ({if_r.o_valid, if_l.o_valid} !== {m_valid, m_valid}) begin
                bad++; $display("FAIL flush_valid cyc%0d: got %b%b want %b", i, if_r.o_valid, if_l.o_valid, m_valid);
            end
        end
        total++;
        if ({if_r.o_data, if_l.o_data} !== {8'sd4, 8'sd4}) begin
            bad++; $display("FAIL flush_pixel: got %0d %0d want 4", if_r.o_data, if_l.o_data);
        end
        drive_cycle(0, 0, 0, 0, 1, ro, re);
    endtask

    task automatic test_reset_mid();
        logic [1:0] ro; bit re;
        for (int i = 0; i < 4; i++) drive_cycle(1, 48, 0, 0, 0, ro, re);
        drive_cycle(1, 16, 0, 0, 0, ro, re);
        drive_cycle(1, 16, 0, 0, 0, ro, re);
        valid = 0;
        #1 rst_n = 0;
        #1;
        total++;
        if ({if_r.o_valid, if_l.o_valid, if_r.o_in_ready} !== 3'b001) begin
            bad++; $display("FAIL reset_mid: got v=%b%b rdy=%b want 00 1", if_r.o_valid, if_l.o_valid, if_r.o_in_ready);
        end
        @(negedge clk); rst_n = 1;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) drive_cycle(1, 16, 0, 0, 1, ro, re);
        total++;
        if ({if_r.o_valid, if_r.o_data, if_l.o_valid, if_l.o_data} !== {1'b1, 8'sd4, 1'b1, 8'sd4}) begin
            bad++; $display("FAIL reset_mid_pixel: got v=%b d=%0d want 1 4", if_r.o_valid, if_r.o_data);
        end
        drive_cycle(0, 0, 0, 0, 1, ro, re);
    endtask

    task automatic test_back_to_back();
        logic [1:0] ro; bit re;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1, int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 400)) - 200, 0, 1, ro, re);
            total++;
            if ({if_r.o_valid, if_r.o_data, if_l.o_valid, if_l.o_data} !== {m_valid, m_dr, m_valid, m_dl}
                || (i % 4 == 3) !== m_valid) begin
                bad++; $display("FAIL b2b cyc%0d: got v=%b r=%0d l=%0d want v=%b r=%0d l=%0d",
                                i, if_r.o_valid, if_r.o_data, if_l.o_data, m_valid, $signed(m_dr), $signed(m_dl));
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] ro; bit re;
        logic [19:0] obs, exp_v;
        for (int i = 0; i < 600; i++) begin
            drive_cycle($urandom_range(0, 9) < 7, int'($urandom_range(0, 65535)) - 32768,
                        int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 19) == 0,
                        $urandom_range(0, 9) < 5, ro, re);
            total++;
            if (ro !== {re, re}) begin
                bad++; $display("FAIL rand_in_ready cyc%0d: got %b want %b", i, ro, re);
            end
            obs   = {if_r.o_valid, if_r.o_valid ? {if_r.o_data, if_r.o_sat} : 9'h0,
                     if_l.o_valid, if_l.o_valid ? {if_l.o_data, if_l.o_sat} : 9'h0};
            exp_v = {m_valid, m_valid ? {m_dr, m_sr} : 9'h0, m_valid, m_valid ? {m_dl, m_sl} : 9'h0};
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL rand_out cyc%0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/convolution_psum_collector.md
Name: convolution_psum_collector

Overview:
- Downstream stage of the first-line convolution MAC. Consumes its saturated 16-bit partial-sum stream, one psum per kernel tap.
- Accumulates K taps per output pixel and adds a bias.
- Applies optional ReLU, an arithmetic right shift and signed saturation to 8 bits, producing one activation per K accepted taps.
- Output side is a valid/ready register stage feeding the next layer's input or line buffer.

Parameters:
I_PSUM, 16, width of incoming signed psum and of the bias
K, 4, taps per output pixel (K >= 2)
ACC, 24, internal signed accumulator width
SHIFT, 4, arithmetic right-shift amount for requantization (0..ACC-1)
RELU, 1, 1 = clamp negatives to 0 before saturation
O_DATA, 8, signed output width

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  i_psum valid this cycle
o_in_ready  output  1  collector can accept i_psum this cycle
i_psum  input  I_PSUM  signed psum from the MAC line
i_bias  input  I_PSUM  signed bias; sampled on the final tap of each pixel
i_flush  input  1  synchronous abort of the partial accumulation
o_valid  output  1  o_data holds a result
i_out_ready  input  1  downstream accepts o_data this cycle
o_data  output  O_DATA  signed requantized activation
o_sat  output  1  result was clipped by saturation; qualified by o_valid

Behaviour:
- Reset (async, i_rst_n=0): tap counter=0, acc=0, o_valid=0, o_data=0, o_sat=0, o_in_ready=1 immediately after reset deasserts.
- Transfer in: fires when i_valid && o_in_ready.
- Transfer out: fires when o_valid && i_out_ready.
- Tap counter counts 0..K-1 and advances only on an input transfer.
- Non-final tap (count < K-1): acc <= acc + sext(i_psum) (count 0 loads acc <= sext(i_psum)); count++.
- Final tap (count = K-1), in this order:
  - sum = acc + sext(i_psum) + sext(i_bias)
  - relu: if RELU and sum<0, sum=0
  - shifted = sum >>> SHIFT (floor, no rounding)
  - saturate to [-2^(O_DATA-1), 2^(O_DATA-1)-1]
  - register into o_data; o_sat <= clipped; o_valid <= 1; count <= 0; acc <= 0.
- Latency: o_valid rises at the clock edge that accepts the final tap (registered output, 1 cycle from sampling).
- Backpressure:
  - o_in_ready = !(count==K-1 && o_valid && !i_out_ready). Combinational; no dependency on i_valid.
  - Non-final taps are always accepted, even while a result is held.
  - Only the final tap stalls, and only while the held result is not being taken.
- Simultaneous output transfer and final-tap input in the same cycle: the new result replaces the old one; o_valid stays 1, no bubble.
- Output transfer with no new result: o_valid <= 0. o_data and o_sat keep their last values (don't-care when o_valid=0).
- o_data and o_sat stay stable while o_valid && !i_out_ready.
- i_flush: count <= 0 and acc <= 0 next edge. Any same-cycle i_psum is dropped (flush wins). A held output result is unaffected.
- Accumulator overflow: ACC is sized so that K*max|psum| + |bias| fits. No wrap checking is required; out-of-range K/ACC combinations are a configuration error.
- Reset mid-accumulation or mid-hold: all state is discarded and any pending output is lost.

Decomposition:
- Shared package (convolution_pkg):
  - default widths: I_PSUM, O_DATA, ACC
  - localparams SAT_MAX = 2^(O_DATA-1)-1 and SAT_MIN = -2^(O_DATA-1), also used by the MAC saturation
  - function for the tap-counter width, clog2(K)
- One natural sub-module: convolution_requant. Purely combinational: sum -> relu -> shift -> saturate, outputs data plus the clip flag. It is reusable by the MAC line's saturation path.
- The collector keeps the counter, accumulator and output register.

Test Plan:
- Basic pixel (defaults, bias 0): psums 100, 200, -50, 10 back-to-back with i_out_ready=1 -> sum 260, >>>4 = 16. o_valid pulses 1 cycle after the 4th tap with o_data=16, o_sat=0.
- Negative with ReLU (RELU=1):
  - psums -100, -100, -100, 0 with bias 0 -> o_data=0, o_sat=0.
  - Rerun with RELU=0 -> -300>>>4 = -19 (floor), o_data=-19.
- Saturation and bias: psums 5000 x4 with bias 100 -> 20100>>>4 = 1256. Output clips to o_data=127, o_sat=1.
- Backpressure: hold i_out_ready=0 after the first result and stream 8 psums of 16.
  - The first 3 taps of the second pixel are accepted.
  - o_in_ready drops at the 4th tap; o_data stays stable.
  - Raise i_out_ready -> first result transfers, the 4th tap is accepted the same cycle, and the second result (4) appears with no gap.
- Flush and reset mid-pixel:
  - psums 100, 100, then i_flush concurrent with a psum of 100 (dropped), then 16 x4 -> o_data=4.
  - Assert i_rst_n=0 after 2 taps -> o_valid=0 immediately; the next 4 taps of 16 yield o_data=4.
